// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked integer ALU. Single-cycle logic/arith/shift ops,
//                iterative radix-2 multiply and restoring divide/remainder.
//                Result and flags are registered and held until retired.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
   parameter int XLEN = 64,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] f,
   output logic            zf,
   output logic            cf,
   output logic            of,
   output logic            sf,
   output logic            pf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SLL   = 4'b0011;
   localparam logic [3:0] OP_SLT   = 4'b0100;
   localparam logic [3:0] OP_SLTU  = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_XOR   = 4'b0111;
   localparam logic [3:0] OP_SRL   = 4'b1000;
   localparam logic [3:0] OP_SRA   = 4'b1001;
   localparam logic [3:0] OP_LUI   = 4'b1010;
   localparam logic [3:0] OP_MUL   = 4'b1011;
   localparam logic [3:0] OP_MULHU = 4'b1100;
   localparam logic [3:0] OP_DIVU  = 4'b1101;
   localparam logic [3:0] OP_REMU  = 4'b1110;

   localparam int          LAST_I   = XLEN - 1;
   localparam logic [SHW:0] CNT_LAST = LAST_I[SHW:0];
   localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};

   state_t              state, state_next;
   logic [3:0]          op_q;
   logic [XLEN-1:0]     a_q, b_q;
   // MUL: {high, low} partial product. DIV: {remainder, dividend/quotient}.
   logic [2*XLEN-1:0]   work, work_next;
   logic [SHW:0]        cnt;

   logic                accept, last, load;
   logic [XLEN-1:0]     alu_f;
   logic                alu_c, alu_arith;
   logic [XLEN-1:0]     res_f;
   logic                res_c, res_of;
   logic [XLEN:0]       mul_sum;
   logic [XLEN:0]       div_trial;
   logic                div_ge;
   logic [XLEN-1:0]     div_sub;

   // State register; reset discards any in-flight iteration.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_next = state;
      in_ready   = (state == S_IDLE);
      out_valid  = (state == S_DONE);
      accept     = in_valid && (state == S_IDLE);
      last       = (cnt == CNT_LAST);
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (op == OP_MUL || op == OP_MULHU)
                  state_next = S_MUL;
               else if ((op == OP_DIVU || op == OP_REMU) && (b != '0))
                  state_next = S_DIV;
               else
                  state_next = S_DONE;
            end
         end
         S_MUL:   if (last) state_next = S_DONE;
         S_DIV:   if (last) state_next = S_DONE;
         S_DONE:  if (out_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Single-cycle result from the live operands (also covers divide-by-zero).
   always_comb begin
      alu_f     = '0;
      alu_c     = 1'b0;
      alu_arith = 1'b0;
      case (op)
         OP_AND:  alu_f = a & b;
         OP_OR:   alu_f = a | b;
         OP_XOR:  alu_f = a ^ b;
         OP_LUI:  alu_f = b;
         OP_ADD: begin
            {alu_c, alu_f} = {1'b0, a} + {1'b0, b};
            alu_arith      = 1'b1;
         end
         OP_SUB: begin
            {alu_c, alu_f} = {1'b0, a} - {1'b0, b};
            alu_arith      = 1'b1;
         end
         OP_SLL:  alu_f = a << b[SHW-1:0];
         OP_SRL:  alu_f = a >> b[SHW-1:0];
         OP_SRA:  alu_f = $signed(a) >>> b[SHW-1:0];
         OP_SLT:  alu_f = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_f = {{(XLEN-1){1'b0}}, (a < b)};
         OP_DIVU: alu_f = '1;
         OP_REMU: alu_f = a;
         default: alu_f = '0;
      endcase
   end

   // One iteration of shift-add multiply or restoring divide, plus result select.
   always_comb begin
      mul_sum   = {1'b0, work[2*XLEN-1:XLEN]} + {1'b0, (b_q[0] ? a_q : {XLEN{1'b0}})};
      div_trial = {work[2*XLEN-1:XLEN], work[XLEN-1]};
      div_ge    = (div_trial >= {1'b0, b_q});
      div_sub   = div_trial[XLEN-1:0] - b_q;
      work_next = work;
      res_f     = alu_f;
      res_c     = 1'b0;
      res_of    = 1'b0;
      load      = 1'b0;
      case (state)
         S_IDLE: begin
            load   = accept && (state_next == S_DONE);
            res_c  = alu_arith & alu_c;
            res_of = alu_arith & (a[XLEN-1] ^ b[XLEN-1] ^ alu_f[XLEN-1] ^ alu_c);
         end
         S_MUL: begin
            work_next = {mul_sum, work[XLEN-1:1]};
            load      = last;
            res_f     = (op_q == OP_MUL) ? work_next[XLEN-1:0] : work_next[2*XLEN-1:XLEN];
         end
         S_DIV: begin
            if (div_ge) work_next = {div_sub, work[XLEN-2:0], 1'b1};
            else        work_next = {div_trial[XLEN-1:0], work[XLEN-2:0], 1'b0};
            load  = last;
            res_f = (op_q == OP_DIVU) ? work_next[XLEN-1:0] : work_next[2*XLEN-1:XLEN];
         end
         default: ;
      endcase
   end

   // Operand capture, iteration state, and registered result/flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         work <= '0;
         cnt  <= '0;
         f    <= '0;
         zf   <= 1'b0;
         cf   <= 1'b0;
         of   <= 1'b0;
         sf   <= 1'b0;
         pf   <= 1'b0;
      end else begin
         if (accept) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            cnt  <= '0;
            if (op == OP_DIVU || op == OP_REMU) work <= {{XLEN{1'b0}}, a};
            else                                work <= '0;
         end else if (state == S_MUL || state == S_DIV) begin
            work <= work_next;
            cnt  <= cnt + CNT_ONE;
            if (state == S_MUL) b_q <= b_q >> 1;
         end
         if (load) begin
            f  <= res_f;
            zf <= (res_f == '0);
            sf <= res_f[XLEN-1];
            pf <= ~^res_f;
            cf <= res_c;
            of <= res_of;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Scoreboard bench for alu_seq: directed cases plus randomized
//                operations against a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      op;
   logic [XLEN-1:0] a, b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] f;
   logic            zf, cf, of, sf, pf;

   typedef struct {
      logic [XLEN-1:0] f;
      logic [4:0]      fl;   // {zf, cf, of, sf, pf}
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   alu_seq #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .f(f), .zf(zf), .cf(cf), .of(of), .sf(sf), .pf(pf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model written directly from the operation rules.
   function automatic exp_t model(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
      exp_t            e;
      logic [XLEN:0]   w;
      logic [2*XLEN-1:0] p;
      logic [XLEN-1:0] r;
      logic            c;
      logic            arith;
      int              sh;
      c     = 1'b0;
      arith = 1'b0;
      r     = '0;
      sh    = int'(y % XLEN);
      p     = {{XLEN{1'b0}}, x} * {{XLEN{1'b0}}, y};
      case (o)
         4'd0:  r = x & y;
         4'd1:  r = x | y;
         4'd7:  r = x ^ y;
         4'd10: r = y;
         4'd2:  begin w = {1'b0, x} + {1'b0, y}; r = w[XLEN-1:0]; c = w[XLEN]; arith = 1'b1; end
         4'd6:  begin w = {1'b0, x} - {1'b0, y}; r = w[XLEN-1:0]; c = w[XLEN]; arith = 1'b1; end
         4'd3:  r = x << sh;
         4'd8:  r = x >> sh;
         4'd9:  r = $signed(x) >>> sh;
         4'd4:  r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
         4'd5:  r = (x < y) ? 64'd1 : 64'd0;
         4'd11: r = p[XLEN-1:0];
         4'd12: r = p[2*XLEN-1:XLEN];
         4'd13: r = (y == 0) ? {XLEN{1'b1}} : x / y;
         4'd14: r = (y == 0) ? x : x % y;
         default: r = '0;
      endcase
      e.f  = r;
      e.fl = {(r == 0), (arith ? c : 1'b0),
              (arith ? (x[XLEN-1] ^ y[XLEN-1] ^ r[XLEN-1] ^ c) : 1'b0),
              r[XLEN-1], ~^r};
      return e;
   endfunction

   function automatic int exp_lat(input logic [3:0] o, input logic [XLEN-1:0] y);
      if (o == 4'd11 || o == 4'd12) return XLEN + 1;
      if ((o == 4'd13 || o == 4'd14) && y != 0) return XLEN + 1;
      return 1;
   endfunction

   // Monitor: pop and compare on every retirement.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual=retire required=none");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result_f", f, e.f);
            chk("result_flags", {59'd0, zf, cf, of, sf, pf}, {59'd0, e.fl});
         end
      end
   end

   task automatic run_op(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                         input int stall);
      int              n;
      bit              ok;
      logic [XLEN-1:0] f_hold;
      logic [4:0]      fl_hold;
      n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      chk("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
      sb.push_back(model(o, x, y));
      op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      n  = 1;
      ok = 1'b1;
      // While busy, throw junk at the inputs; none of it may be taken.
      while (!out_valid && n < 200) begin
         if (in_ready) ok = 1'b0;
         in_valid = 1'($urandom_range(0, 1));
         op = 4'($urandom);
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom};
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      chk("latency", 64'(n), 64'(exp_lat(o, y)));
      chk("busy_in_ready_low", {63'd0, ok}, 64'd1);
      f_hold  = f;
      fl_hold = {zf, cf, of, sf, pf};
      ok      = 1'b1;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         if (f !== f_hold || {zf, cf, of, sf, pf} !== fl_hold || !out_valid || in_ready) ok = 1'b0;
      end
      if (stall > 0) chk("backpressure_hold", {63'd0, ok}, 64'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_retire_in_ready", {62'd0, in_ready, out_valid}, 64'b10);
   endtask

   function automatic logic [XLEN-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return {XLEN{1'b1}};
         2: return 64'h8000_0000_0000_0000;
         3: return 64'($urandom_range(0, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_state", {58'd0, in_ready, out_valid, zf, cf, of, sf}, 64'b100000);
      chk("reset_f_pf", f | {63'd0, pf}, 64'd0);

      // Directed cases
      run_op(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
      run_op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
      run_op(4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
      run_op(4'b0101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
      run_op(4'b0110, 64'd3, 64'd5, 0);
      run_op(4'b1011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
      run_op(4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
      run_op(4'b1101, 64'd100, 64'd7, 0);
      run_op(4'b1110, 64'd100, 64'd7, 0);
      run_op(4'b1101, 64'd100, 64'd0, 0);
      run_op(4'b1110, 64'd5, 64'd0, 0);
      run_op(4'b1101, 64'd100, 64'd7, 10);
      run_op(4'b1111, 64'd9, 64'd9, 2);

      // Reset in the middle of a multiply
      op = 4'b1011; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd2; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_mul_reset_ctrl", {62'd0, in_ready, out_valid}, 64'b10);
      chk("mid_mul_reset_f", f, 64'd0);
      chk("mid_mul_reset_flags", {59'd0, zf, cf, of, sf, pf}, 64'd0);
      run_op(4'b1001, 64'h8000_0000_0000_0000, 64'h43, 0);

      // Randomized operations
      for (int k = 0; k < 40; k++) begin
         run_op(4'($urandom), rand_operand(), rand_operand(), int'($urandom_range(0, 3)));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor of the single-cycle integer ALU in the execute stage.
- Adds iterative multiply and divide/remainder, which take XLEN cycles.
- Registers the result and the five flags, and holds them until the consumer accepts.
- Every operation goes through one valid/ready pipeline slot, so the execute stage can stall on long ops without special-casing.

Parameters:
- XLEN, 64: operand and result width. Must be a power of two, minimum 8.
- SHW, $clog2(XLEN): number of B bits used as the shift amount. Derived; not to be overridden.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operation request is present.
- in_ready  out  1  block can accept a request. Equals (state==IDLE).
- op  in  4  operation code (see Behaviour).
- a  in  XLEN  operand A (rs1).
- b  in  XLEN  operand B (rs2 or immediate).
- out_valid  out  1  f and the flags hold a valid result.
- out_ready  in  1  consumer accepts the result.
- f  out  XLEN  result.
- zf, cf, of, sf, pf  out  1 each  zero, carry, overflow, sign and even-parity flags.

Behaviour:
- Handshake:
  - Accept when in_valid && in_ready; a, b and op are latched on that edge.
  - Result retires when out_valid && out_ready.
  - In DONE, f and the flags stay stable until retirement.
  - in_ready=0 in every state other than IDLE; there is no overlap of requests.
- Op codes (f):
  - 0000 AND; 0001 OR; 0111 XOR; 1010 pass B (lui).
  - 0010 ADD: {c,f}=a+b, XLEN+1 bits. 0110 SUB: {c,f}=a-b, so c=1 on borrow.
  - 0011 SLL a<<b[SHW-1:0]; 1000 SRL logical; 1001 SRA arithmetic. Upper B bits are ignored.
  - 0100 SLT signed, 0101 SLTU unsigned: f is 1 or 0, zero-extended.
  - 1011 MUL: low XLEN bits of a*b. 1100 MULHU: high XLEN bits of unsigned a*b.
  - 1101 DIVU: unsigned quotient. 1110 REMU: unsigned remainder.
  - 1111 reserved: f=0, flags computed from f=0, latency 1.
- Flags, registered together with f:
  - zf = (f==0).
  - sf = f[XLEN-1].
  - pf = ~^f.
  - cf = c for ADD/SUB, else 0.
  - of = a[XLEN-1]^b[XLEN-1]^f[XLEN-1]^c for ADD/SUB, else 0.
- State machine, states IDLE, MUL, DIV, DONE:
  - IDLE, accept of an op in 0000-1010 or 1111: compute and register, go to DONE. out_valid rises in cycle T+1, where T is the accept edge.
  - IDLE, accept of 1011/1100: clear the 2*XLEN product and the counter, go to MUL.
    - MUL is radix-2 shift-add, one multiplier bit per cycle, XLEN cycles, then DONE.
    - out_valid rises at T+XLEN+1.
  - IDLE, accept of 1101/1110 with b!=0: go to DIV.
    - DIV is restoring division, one quotient bit per cycle, XLEN cycles, then DONE.
    - out_valid rises at T+XLEN+1.
  - IDLE, accept of 1101/1110 with b==0: go straight to DONE, latency 1. DIVU gives f=all ones; REMU gives f=a.
  - DONE, out_valid && out_ready: go to IDLE. in_ready=1 on the following cycle; there is no same-cycle re-accept.
- Counter: width SHW+1. It counts 0..XLEN-1 and the last iteration is at count==XLEN-1. Wrap beyond that is not permitted.
- Reset, including mid-MUL/DIV or while in DONE:
  - state=IDLE, out_valid=0, f=0, all flags=0. The partial result is discarded.
  - in_ready=1 on the first cycle after rst deasserts.
- Inputs while busy: in_valid is ignored and a/b changes have no effect.

Test Plan:
- ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> one cycle later out_valid=1, f=0, zf=1, cf=1, of=0, pf=1.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> f=0x8000_0000_0000_0000, of=1, sf=1, cf=0. SLT a=-1, b=0 -> f=1. SLTU on the same operands -> f=0.
- MUL a=0xFFFF_FFFF_FFFF_FFFF, b=2:
  - in_ready=0 for 65 cycles; out_valid at T+65; f=0xFFFF_FFFF_FFFF_FFFE.
  - MULHU on the same operands -> f=1.
- DIVU a=100, b=7 -> f=14 at T+65. REMU -> f=2. DIVU b=0 -> f=all ones at T+1. REMU a=5, b=0 -> f=5.
- Backpressure: hold out_ready=0 for 10 cycles after a DIVU result -> f and flags stable, in_ready=0. Raise out_ready -> retire, then in_ready=1 next cycle.
- Assert rst at iteration 30 of a MUL -> next cycle out_valid=0, f=0, in_ready=1. A following SRA a=0x8000_0000_0000_0000, b=0x43 -> f=0xF000_0000_0000_0000, since only b[5:0]=3 is used.
